// File: rtl/logic_gate_pkg.sv
// Shared definitions for logic_gate_pipe: operation encoding, result buffer
// depth and buffer occupancy states.
package logic_gate_pkg;

  localparam int unsigned BUF_DEPTH = 2;

  typedef enum logic [2:0] {
    MODE_AND  = 3'd0,
    MODE_OR   = 3'd1,
    MODE_XOR  = 3'd2,
    MODE_NAND = 3'd3,
    MODE_NOR  = 3'd4,
    MODE_XNOR = 3'd5,
    MODE_PASS = 3'd6,
    MODE_INV  = 3'd7
  } mode_e;

  typedef enum logic [1:0] {
    CNT_EMPTY,
    CNT_ONE,
    CNT_FULL
  } cnt_e;

  // Number of buffered results represented by an occupancy state.
  function automatic int unsigned occupancy(input cnt_e s);
    case (s)
      CNT_EMPTY: return 0;
      CNT_ONE:   return 1;
      default:   return 2;
    endcase
  endfunction

endpackage

// File: rtl/logic_gate_pipe_reduce.sv
// gate_reduce: combinational bitwise reduction across NUM_IN operands of
// WIDTH bits, selected by mode.
module gate_reduce
  import logic_gate_pkg::*;
#(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned NUM_IN = 2
) (
  input  logic [NUM_IN*WIDTH-1:0] data,
  input  logic [2:0]              mode,
  output logic [WIDTH-1:0]        result
);

  logic [WIDTH-1:0] red_and;
  logic [WIDTH-1:0] red_or;
  logic [WIDTH-1:0] red_xor;
  logic [WIDTH-1:0] op0;

  assign op0 = data[WIDTH-1:0];

  // Fold every operand into the three base reductions.
  always_comb begin
    red_and = '1;
    red_or  = '0;
    red_xor = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      red_and = red_and & data[k*WIDTH +: WIDTH];
      red_or  = red_or  | data[k*WIDTH +: WIDTH];
      red_xor = red_xor ^ data[k*WIDTH +: WIDTH];
    end
  end

  // Select the requested operation.
  always_comb begin
    result = '0;
    case (mode_e'(mode))
      MODE_AND:  result = red_and;
      MODE_OR:   result = red_or;
      MODE_XOR:  result = red_xor;
      MODE_NAND: result = ~red_and;
      MODE_NOR:  result = ~red_or;
      MODE_XNOR: result = ~red_xor;
      MODE_PASS: result = op0;
      MODE_INV:  result = ~op0;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: valid/ready wrapper around gate_reduce with a 2-entry
// in-order result buffer and 1-cycle latency.
// Optional feature: define LOGIC_GATE_PIPE_PARITY_EN to add OUT_PAR, the
// stored XOR of all bits of each buffered result.
module logic_gate_pipe
  import logic_gate_pkg::*;
#(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned NUM_IN = 2
) (
  input  logic                    CLK,
  input  logic                    RSTn,
  input  logic [NUM_IN*WIDTH-1:0] IN_DATA,
  input  logic [2:0]              MODE,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  output logic [WIDTH-1:0]        OUT_DATA,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY
`ifdef LOGIC_GATE_PIPE_PARITY_EN
  ,
  output logic                    OUT_PAR
`endif
);

  cnt_e             state;
  cnt_e             state_next;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic             push;
  logic             pop;
  logic             load_head_new;
  logic             load_head_tail;
  logic             load_tail;

  gate_reduce #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_reduce (
    .data   (IN_DATA),
    .mode   (MODE),
    .result (result)
  );

  assign push = IN_VALID & IN_READY;
  assign pop  = OUT_VALID & OUT_READY;

  // Head is what OUT_DATA shows; tail only holds the second entry.
  // A push meeting a pop at one entry replaces the head directly.
  assign load_head_new  = push & ((state == CNT_EMPTY) | pop);
  assign load_head_tail = pop & (state == CNT_FULL);
  assign load_tail      = push & ~pop & (state == CNT_ONE);

  // Occupancy state register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= CNT_EMPTY;
    else       state <= state_next;
  end

  // Occupancy transitions from push/pop.
  always_comb begin
    state_next = state;
    case (state)
      CNT_EMPTY: if (push) state_next = CNT_ONE;
      CNT_ONE: begin
        if (push && !pop)      state_next = CNT_FULL;
        else if (pop && !push) state_next = CNT_EMPTY;
      end
      CNT_FULL:  if (pop) state_next = CNT_ONE;
      default:   state_next = CNT_EMPTY;
    endcase
  end

  // Handshake flags decoded from registered occupancy only.
  always_comb begin
    IN_READY  = occupancy(state) < BUF_DEPTH;
    OUT_VALID = occupancy(state) > 0;
  end

  // Result buffer entries.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (load_head_new)       head <= result;
      else if (load_head_tail) head <= tail;
      if (load_tail)           tail <= result;
    end
  end

  assign OUT_DATA = head;

`ifdef LOGIC_GATE_PIPE_PARITY_EN
  logic par_head;
  logic par_tail;

  // Parity stored alongside each buffer entry.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      par_head <= 1'b0;
      par_tail <= 1'b0;
    end else begin
      if (load_head_new)       par_head <= ^result;
      else if (load_head_tail) par_head <= par_tail;
      if (load_tail)           par_tail <= ^result;
    end
  end

  assign OUT_PAR = par_head;
`endif

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Self-checking bench for logic_gate_pipe (WIDTH=4, NUM_IN=3): directed
// literal checks plus randomized traffic against a queue-based model.
module tb_logic_gate_pipe;

  localparam int unsigned W = 4;
  localparam int unsigned N = 3;

  logic           CLK = 1'b0;
  logic           RSTn = 1'b0;
  logic [N*W-1:0] IN_DATA = '0;
  logic [2:0]     MODE = '0;
  logic           IN_VALID = 1'b0;
  logic           IN_READY;
  logic [W-1:0]   OUT_DATA;
  logic           OUT_VALID;
  logic           OUT_READY = 1'b0;
`ifdef LOGIC_GATE_PIPE_PARITY_EN
  logic           OUT_PAR;
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] m_last = '0;

  logic [N*W-1:0] tmp;

  logic_gate_pipe #(
    .WIDTH  (W),
    .NUM_IN (N)
  ) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .IN_DATA   (IN_DATA),
    .MODE      (MODE),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .OUT_DATA  (OUT_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY)
`ifdef LOGIC_GATE_PIPE_PARITY_EN
    ,
    .OUT_PAR   (OUT_PAR)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model_res(input logic [N*W-1:0] d, input logic [2:0] m);
    logic [W-1:0] ops[N];
    logic [W-1:0] a, o, x;
    a = 4'hF; o = 4'h0; x = 4'h0;
    for (int k = 0; k < N; k++) begin
      ops[k] = d[k*W +: W];
      a = a & ops[k];
      o = o | ops[k];
      x = x ^ ops[k];
    end
    case (m)
      3'd0: return a;
      3'd1: return o;
      3'd2: return x;
      3'd3: return ~a;
      3'd4: return ~o;
      3'd5: return ~x;
      3'd6: return ops[0];
      default: return ~ops[0];
    endcase
  endfunction

  // Reference model: FIFO of results, head remembered when empty.
  always @(posedge CLK or negedge RSTn) begin
    bit p_in, p_out;
    if (!RSTn) begin
      mq.delete();
      m_last = '0;
    end else begin
      p_in  = IN_VALID && (mq.size() < 2);
      p_out = (mq.size() > 0) && OUT_READY;
      tmp   = IN_DATA;
      if (p_out) void'(mq.pop_front());
      if (p_in) mq.push_back(model_res(tmp, MODE));
      if (mq.size() > 0) m_last = mq[0];
    end
  end

  // Cycle-by-cycle compare of DUT outputs against the model.
  always @(negedge CLK) begin
    if (RSTn) begin
      check("cmp_out_valid", OUT_VALID, mq.size() > 0);
      check("cmp_in_ready", IN_READY, mq.size() < 2);
      check("cmp_out_data", OUT_DATA, m_last);
`ifdef LOGIC_GATE_PIPE_PARITY_EN
      check("cmp_out_par", OUT_PAR, ^m_last);
`endif
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #12;
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_out_data", OUT_DATA, 0);
    check("rst_in_ready", IN_READY, 1);
`ifdef LOGIC_GATE_PIPE_PARITY_EN
    check("rst_out_par", OUT_PAR, 0);
`endif
    @(negedge CLK);
    RSTn = 1'b1;

    // OR of 4,2,1 accepted on the first edge after reset release
    IN_DATA = {4'h4, 4'h2, 4'h1}; MODE = 3'd1; IN_VALID = 1'b1; OUT_READY = 1'b1;
    step();
    check("or_data", OUT_DATA, 4'h7);
    check("or_model", m_last, 4'h7);
    check("or_valid", OUT_VALID, 1);
    IN_VALID = 1'b0;
    step();
    check("or_valid_drop", OUT_VALID, 0);
    check("or_data_hold", OUT_DATA, 4'h7);

    // NAND and INV
    IN_VALID = 1'b1; MODE = 3'd3; IN_DATA = {4'hF, 4'hF, 4'hE};
    step();
    check("nand_1", OUT_DATA, 4'h1);
    IN_DATA = {4'hF, 4'hF, 4'hF};
    step();
    check("nand_0", OUT_DATA, 4'h0);
    MODE = 3'd7; IN_DATA = {4'h0, 4'h0, 4'hA};
    step();
    check("inv_a", OUT_DATA, 4'h5);
    check("inv_model", m_last, 4'h5);
    IN_VALID = 1'b0;
    step();

    // Backpressure: three pushes with OUT_READY low
    OUT_READY = 1'b0; IN_VALID = 1'b1;
    MODE = 3'd0; IN_DATA = {4'hF, 4'h3, 4'h7};
    step();
    MODE = 3'd1; IN_DATA = {4'h1, 4'h2, 4'h4};
    step();
    check("bp_ready_low", IN_READY, 0);
    MODE = 3'd5; IN_DATA = {4'h0, 4'h0, 4'h0};
    step();
    check("bp_held_ready", IN_READY, 0);
    check("bp_head_stable", OUT_DATA, 4'h3);
    step();
    check("bp_head_stable2", OUT_DATA, 4'h3);
    OUT_READY = 1'b1;
    step();
    check("bp_second", OUT_DATA, 4'h7);
    step();
    check("bp_third", OUT_DATA, 4'hF);
    IN_VALID = 1'b0;
    step();
    check("bp_drained", OUT_VALID, 0);
    check("bp_last_hold", OUT_DATA, 4'hF);

    // Simultaneous push/pop at one entry for 10 cycles
    OUT_READY = 1'b0; IN_VALID = 1'b1; MODE = 3'd6; IN_DATA = 12'h009;
    step();
    OUT_READY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      MODE = 3'($urandom_range(0, 7));
      IN_DATA = 12'($urandom);
      step();
      check("pp_valid", OUT_VALID, 1);
      check("pp_ready", IN_READY, 1);
    end
    IN_VALID = 1'b0;
    step();
    check("pp_drained", OUT_VALID, 0);

    // Reset while full
    OUT_READY = 1'b0; IN_VALID = 1'b1; MODE = 3'd2; IN_DATA = 12'h123;
    step();
    step();
    check("full_ready", IN_READY, 0);
    #2 RSTn = 1'b0;
    #1;
    check("mrst_valid", OUT_VALID, 0);
    check("mrst_data", OUT_DATA, 0);
    check("mrst_ready", IN_READY, 1);
    @(negedge CLK);
    RSTn = 1'b1;
    check("mrst_no_xfer", OUT_VALID, 0);
    IN_DATA = {4'h4, 4'h2, 4'h1}; MODE = 3'd2; OUT_READY = 1'b1;
    step();
    check("mrst_fresh", OUT_DATA, 4'h7);
    check("mrst_fresh_valid", OUT_VALID, 1);
    IN_VALID = 1'b0;
    step();

`ifdef LOGIC_GATE_PIPE_PARITY_EN
    IN_VALID = 1'b1; MODE = 3'd2; IN_DATA = {4'h0, 4'h0, 4'h7};
    step();
    check("par_7", OUT_PAR, 1);
    IN_DATA = {4'h0, 4'h0, 4'h3};
    step();
    check("par_3", OUT_PAR, 0);
    IN_VALID = 1'b0;
    step();
`endif

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      IN_VALID  = 1'($urandom_range(0, 3) != 0);
      OUT_READY = 1'($urandom_range(0, 2) != 0);
      MODE      = 3'($urandom_range(0, 7));
      IN_DATA   = 12'($urandom);
      step();
    end
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    step();
    step();
    step();
    check("final_empty", OUT_VALID, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
